// File: rtl/product_bcd_converter.sv
// Iterative double-dabble stage that turns the multiplier's 16-bit magnitude and sign
// into packed BCD digits plus a display minus flag, one bit per clock.
module product_bcd_converter #(
   parameter int IN_W   = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  product_valid,
   input  logic [IN_W-1:0]       product,
   input  logic                  sign,
   output logic                  busy,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]            state;
   logic                  pv_q;
   logic [IN_W-1:0]       shreg;
   logic [BCD_W-1:0]      scratch;
   logic [CNT_W-1:0]      count;
   logic                  sign_q;
   logic                  zero_q;

   logic                  trigger;
   logic                  last_iter;
   logic [BCD_W-1:0]      adjusted;
   logic [BCD_W+IN_W-1:0] combined;
   logic [BCD_W-1:0]      next_scratch;
   logic [IN_W-1:0]       next_shreg;

   // Only a fresh rising edge of the multiplier's done level starts work, and only when idle.
   assign trigger   = product_valid & ~pv_q & (state == IDLE);
   assign last_iter = (count == CNT_W'(IN_W - 1));

   // One double-dabble step: correct every nibble that would overflow past 9, then shift.
   always_comb begin
      adjusted = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) begin
            adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
      end
      combined     = {adjusted, shreg} << 1;
      next_scratch = combined[BCD_W+IN_W-1 -: BCD_W];
      next_shreg   = combined[IN_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pv_q    <= 1'b0;
         shreg   <= '0;
         scratch <= '0;
         count   <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         busy    <= 1'b0;
         valid   <= 1'b0;
         bcd     <= '0;
         neg     <= 1'b0;
      end else begin
         pv_q <= product_valid;
         case (state)
            IDLE: begin
               if (trigger) begin
                  shreg   <= product;
                  scratch <= '0;
                  count   <= '0;
                  sign_q  <= sign;
                  zero_q  <= (product == '0);
                  busy    <= 1'b1;
                  valid   <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= next_scratch;
               shreg   <= next_shreg;
               count   <= count + 1'b1;
               // Zero is never shown as negative, whatever sign the multiplier reported.
               if (last_iter) begin
                  bcd   <= next_scratch;
                  neg   <= sign_q & ~zero_q;
                  valid <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: vector table plus hand-written
// sequences for held, glitched and reset-interrupted conversions, with a result scoreboard.
module tb_product_bcd_converter;

   typedef struct {
      logic [15:0] product;
      logic        sign;
      logic [19:0] exp_bcd;
      logic        exp_neg;
   } vec_t;

   typedef struct {
      logic [19:0] bcd;
      logic        neg;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        product_valid;
   logic [15:0] product;
   logic        sign;
   logic        busy;
   logic        valid;
   logic [19:0] bcd;
   logic        neg;

   int   checks;
   int   failures;
   exp_t sb_q[$];
   vec_t vecs[$];

   product_bcd_converter #(.IN_W(16), .DIGITS(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .product_valid (product_valid),
      .product       (product),
      .sign          (sign),
      .busy          (busy),
      .valid         (valid),
      .bcd           (bcd),
      .neg           (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference conversion by repeated division, independent of the shift-add datapath.
   function automatic logic [19:0] toBcd(input int v);
      logic [19:0] r;
      int          x;
      r = '0;
      x = v;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one conversion from the cycle before its trigger edge up to valid, checking latency.
   task automatic waitResult(input int glitch_at);
      int   steps;
      int   busy_cycles;
      bit   done;
      exp_t e;
      steps       = 0;
      busy_cycles = 0;
      done        = 1'b0;
      while (!done && steps < 40) begin
         step();
         steps++;
         checkOutput("busy_valid_overlap", {31'd0, busy & valid}, 32'd0);
         if (steps == 1) begin
            checkOutput("trigger_busy", {31'd0, busy}, 32'd1);
            checkOutput("trigger_valid_drop", {31'd0, valid}, 32'd0);
         end
         if (busy) busy_cycles++;
         if (glitch_at > 0 && steps == glitch_at) begin
            product_valid = 1'b0;
            product       = 16'd9999;
         end
         if (glitch_at > 0 && steps == glitch_at + 1) product_valid = 1'b1;
         if (valid) done = 1'b1;
      end
      checkOutput("latency_edges", steps, 32'd17);
      checkOutput("busy_cycles", busy_cycles, 32'd16);
      if (done) begin
         if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            checkOutput("bcd", {12'd0, bcd}, {12'd0, e.bcd});
            checkOutput("neg", {31'd0, neg}, {31'd0, e.neg});
         end
      end
   endtask

   task automatic applyStimulus(input logic [15:0] p, input logic s, input logic [19:0] eb,
                                input logic en, input int glitch_at);
      exp_t e;
      product_valid = 1'b0;
      step();
      product       = p;
      sign          = s;
      product_valid = 1'b1;
      e.bcd = eb;
      e.neg = en;
      sb_q.push_back(e);
      waitResult(glitch_at);
   endtask

   initial begin
      int   extra_busy;
      exp_t e;
      vec_t v;

      checks   = 0;
      failures = 0;

      vecs.push_back('{16'd16384, 1'b1, 20'h16384, 1'b1});
      vecs.push_back('{16'd0,     1'b1, 20'h00000, 1'b0});
      vecs.push_back('{16'd65535, 1'b0, 20'h65535, 1'b0});
      vecs.push_back('{16'd99,    1'b0, 20'h00099, 1'b0});
      vecs.push_back('{16'd5,     1'b0, 20'h00005, 1'b0});
      vecs.push_back('{16'd1,     1'b1, 20'h00001, 1'b1});
      vecs.push_back('{16'd10000, 1'b0, 20'h10000, 1'b0});
      vecs.push_back('{16'd59999, 1'b1, 20'h59999, 1'b1});
      vecs.push_back('{16'd49,    1'b1, 20'h00049, 1'b1});
      for (int i = 0; i < 6; i++) begin
         v.product = 16'($urandom_range(0, 65535));
         v.sign    = 1'($urandom_range(0, 1));
         v.exp_bcd = toBcd(int'(v.product));
         v.exp_neg = v.sign & (v.product != 16'd0);
         vecs.push_back(v);
      end

      rst_n         = 1'b0;
      product_valid = 1'b0;
      product       = '0;
      sign          = 1'b0;
      #3;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid}, 32'd0);
      checkOutput("reset_bcd", {12'd0, bcd}, 32'd0);
      checkOutput("reset_neg", {31'd0, neg}, 32'd0);
      step();
      step();
      rst_n = 1'b1;

      $display("[TB] vector table");
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].product, vecs[i].sign, vecs[i].exp_bcd, vecs[i].exp_neg, 0);
      end

      $display("[TB] held product_valid");
      applyStimulus(16'd7, 1'b0, 20'h00007, 1'b0, 0);
      extra_busy = 0;
      repeat (23) begin
         step();
         if (busy) extra_busy++;
      end
      checkOutput("hold_extra_busy", extra_busy, 32'd0);
      checkOutput("hold_valid", {31'd0, valid}, 32'd1);
      checkOutput("hold_bcd", {12'd0, bcd}, 32'h00007);

      $display("[TB] glitched product_valid");
      applyStimulus(16'd1234, 1'b0, 20'h01234, 1'b0, 5);
      applyStimulus(16'd4321, 1'b1, 20'h04321, 1'b1, 0);

      $display("[TB] reset mid-conversion");
      product_valid = 1'b0;
      step();
      product       = 16'd500;
      sign          = 1'b0;
      product_valid = 1'b1;
      e.bcd = 20'h00500;
      e.neg = 1'b0;
      sb_q.push_back(e);
      repeat (9) step();
      checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_valid", {31'd0, valid}, 32'd0);
      checkOutput("abort_bcd", {12'd0, bcd}, 32'd0);
      checkOutput("abort_neg", {31'd0, neg}, 32'd0);
      #1;
      rst_n = 1'b1;
      waitResult(0);

      checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential binary-to-BCD stage placed directly downstream of the signed 8x8 shift-add multiplier. It watches the multiplier's `done` level, captures the 16-bit magnitude `product` and the `sign` bit on its rising edge, and converts the magnitude to five BCD digits with an iterative double-dabble datapath (one bit per clock). It presents digits plus a display sign flag to the seven-segment display logic.

## Interface
Parameters:
- `IN_W`, 16: width of the binary magnitude input.
- `DIGITS`, 5: number of BCD digits produced. Must satisfy 10^DIGITS > 2^IN_W - 1.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `product_valid`  in  1  the multiplier's `done` level; a conversion is triggered by its 0->1 transition.
- `product`  in  IN_W  unsigned magnitude from the multiplier.
- `sign`  in  1  result sign from the multiplier (1 = negative).
- `busy`  out  1  high while a conversion is in progress.
- `valid`  out  1  high while `bcd`/`neg` hold a completed result.
- `bcd`  out  4*DIGITS  packed BCD; digit 0 (units) in [3:0], most significant digit in the top nibble.
- `neg`  out  1  display minus sign.

## Operation
- Edge detect: register `pv_q` samples `product_valid` every cycle. Trigger = `product_valid & ~pv_q` while in IDLE.
- FSM states: IDLE, SHIFT.
  - IDLE: on trigger, load shift register with `product`, clear BCD scratch to 0, clear iteration counter to 0, latch `sign_q = sign`, `zero_q = (product == 0)`, set `busy = 1`, clear `valid = 0`, go to SHIFT.
  - SHIFT: each cycle, for every scratch digit, add 3 if the digit is >= 5. Then shift {scratch, shift register} left by one. Increment the counter.
  - On the iteration with counter == IN_W-1: write the shifted scratch into `bcd`, set `neg = sign_q & ~zero_q`, `valid = 1`, `busy = 0`, and return to IDLE.
- No negative zero: product 0 with sign 1 yields `neg = 0`.
- Triggers are ignored while in SHIFT. This includes a `product_valid` that falls and rises again mid-conversion. A new trigger is accepted only in IDLE, and `pv_q` still tracks the input every cycle.
- A held-high `product_valid` produces exactly one conversion.
- `bcd`/`neg` hold their last result until the next conversion completes. `valid` drops on the trigger edge of the next conversion.
- Width rule: the scratch register is 4*DIGITS bits, and the add-3 is applied per nibble. Digits never exceed 9 after a completed conversion for any input in 0..2^IN_W-1.

## Timing
- Reset (async assert, `rst_n = 0`) sets all of the following immediately, independent of `clk`: state = IDLE, `pv_q = 0`, `busy = 0`, `valid = 0`, `bcd = 0`, `neg = 0`, counter = 0.
- If `product_valid` is already high when reset deasserts, the first clock edge counts as a trigger, because `pv_q` was reset to 0.
- Latency:
  - Edge E0 samples the trigger and sets `busy = 1`.
  - Edges E1..E16 perform the 16 iterations.
  - After E16, `valid = 1`, `busy = 0`, and the result is visible.
  - Total: 16 cycles from the trigger edge to valid output, for IN_W = 16 (IN_W cycles in general).
- Minimum spacing between accepted triggers is IN_W+1 edges, since the earliest re-trigger is at E17.
- Reset mid-conversion aborts the conversion, clears the partial result, and leaves `valid = 0`.
- `busy` and `valid` are never high simultaneously.

## Test plan
- Reset, then `product = 16384`, `sign = 1`, raise `product_valid` -> 16 cycles after the trigger edge: `bcd = 0x16384`, `neg = 1`, `valid = 1`, `busy = 0`.
- `product = 0`, `sign = 1` -> `bcd = 0x00000`, `neg = 0` (no negative zero).
- `product = 65535`, `sign = 0` -> `bcd = 0x65535`, `neg = 0`. Also check `product = 99` -> `bcd = 0x00099`, which exercises the add-3 boundary at 5.
- Hold `product_valid` high for 40 cycles with `product = 7` -> exactly one conversion; `busy` high for exactly 16 cycles; `bcd = 0x00007`.
- Pulse `product_valid` low then high at cycle 5 of a conversion of 1234 -> second edge ignored; result `0x01234`. A new rising edge after completion converts the new value and drops `valid` on its trigger edge.
- Assert `rst_n = 0` asynchronously at cycle 8 of a conversion of 500 -> `busy`, `valid`, `bcd` and `neg` go to 0 immediately. After release plus a fresh trigger, 500 converts to `0x00500`.
